// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage and its load aligner.
package wb_pkg;

  localparam int unsigned SRC_ALU = 0;
  localparam int unsigned SRC_MEM = 1;
  localparam int unsigned SRC_PC  = 2;

  typedef enum logic [1:0] {
    MS_WORD = 2'b00,
    MS_HALF = 2'b01,
    MS_BYTE = 2'b10
  } mem_size_t;

  // Width-independent control fields of the stage register.
  typedef struct packed {
    logic      wb_en;
    mem_size_t mem_size;
    logic      mem_signed;
    logic      ret;
  } wb_ctrl_t;

  // Encoding 2'b11 is treated as a word access.
  function automatic mem_size_t decode_size(input logic [1:0] s);
    case (s)
      2'b01:   return MS_HALF;
      2'b10:   return MS_BYTE;
      default: return MS_WORD;
    endcase
  endfunction

endpackage

// File: rtl/wb_stage_p_if.sv
// Instruction input bundle and register-file commit outputs of the writeback stage.
interface wb_stage_p_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned NSRC   = 3
);
  localparam int unsigned SEL_W = $clog2(NSRC);
  localparam int unsigned OFF_W = $clog2(DATA_W / 8);

  logic                   in_valid;
  logic                   in_wb_en;
  logic [ADDR_W-1:0]      in_wb_addr;
  logic [SEL_W-1:0]       in_src_sel;
  logic [NSRC*DATA_W-1:0] in_src_data;
  logic [1:0]             in_mem_size;
  logic                   in_mem_signed;
  logic [OFF_W-1:0]       in_byte_off;
  logic                   in_ret;
  logic [DATA_W-1:0]      in_pcret;

  logic                   reg_we;
  logic [ADDR_W-1:0]      reg_waddr;
  logic [DATA_W-1:0]      reg_wdata;
  logic                   ret;
  logic [DATA_W-1:0]      pcret;

  modport master (
    output in_valid, in_wb_en, in_wb_addr, in_src_sel, in_src_data,
           in_mem_size, in_mem_signed, in_byte_off, in_ret, in_pcret,
    input  reg_we, reg_waddr, reg_wdata, ret, pcret
  );

  modport slave (
    input  in_valid, in_wb_en, in_wb_addr, in_src_sel, in_src_data,
           in_mem_size, in_mem_signed, in_byte_off, in_ret, in_pcret,
    output reg_we, reg_waddr, reg_wdata, ret, pcret
  );
endinterface

// File: rtl/wb_load_align.sv
// Sub-word load alignment: selects byte/half at the given offset and sign/zero extends.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] data,
  input  mem_size_t         size,
  input  logic              mem_signed,
  input  logic [OFF_W-1:0]  off,
  output logic [DATA_W-1:0] aligned
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    // Halfword offset drops the low byte-offset bit; out-of-range shifts yield zero.
    byte_v  = 8'(data >> {off, 3'b000});
    half_v  = 16'(data >> {off >> 1, 4'b0000});
    aligned = data;
    case (size)
      MS_BYTE: begin
        aligned      = {DATA_W{mem_signed & byte_v[7]}};
        aligned[7:0] = byte_v;
      end
      MS_HALF: begin
        aligned       = {DATA_W{mem_signed & half_v[15]}};
        aligned[15:0] = half_v;
      end
      default: aligned = data;
    endcase
  end

endmodule

// File: rtl/wb_stage_p.sv
// MEM/WB writeback stage: stall/flush stage register, single-commit write, bypass register, counters.
module wb_stage_p
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned NSRC    = 3,
  parameter int unsigned CNT_W   = 16,
  parameter bit          R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  wb_stage_p_if.slave       bus,
  output logic              byp_valid,
  output logic [ADDR_W-1:0] byp_addr,
  output logic [DATA_W-1:0] byp_data,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int unsigned SEL_W = $clog2(NSRC);
  localparam int unsigned OFF_W = $clog2(DATA_W / 8);

  logic                   valid_q;
  logic                   done_q;
  wb_ctrl_t               ctrl_q;
  logic [ADDR_W-1:0]      waddr_q;
  logic [SEL_W-1:0]       sel_q;
  logic [NSRC*DATA_W-1:0] src_q;
  logic [OFF_W-1:0]       off_q;
  logic [DATA_W-1:0]      pcret_q;

  logic                   commit;
  logic                   we;
  logic [DATA_W-1:0]      aligned;
  logic [DATA_W-1:0]      wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ctrl_q  <= '0;
      waddr_q <= '0;
      sel_q   <= '0;
      src_q   <= '0;
      off_q   <= '0;
      pcret_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (stall) begin
      // A held entry marks itself done on its commit edge so it never writes twice.
      done_q <= done_q | valid_q;
    end else begin
      valid_q         <= bus.in_valid;
      done_q          <= 1'b0;
      ctrl_q.wb_en    <= bus.in_wb_en;
      ctrl_q.mem_size <= decode_size(bus.in_mem_size);
      ctrl_q.mem_signed <= bus.in_mem_signed;
      ctrl_q.ret      <= bus.in_ret;
      waddr_q         <= bus.in_wb_addr;
      sel_q           <= bus.in_src_sel;
      src_q           <= bus.in_src_data;
      off_q           <= bus.in_byte_off;
      pcret_q         <= bus.in_pcret;
    end
  end

  wb_load_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_align (
    .data       (src_q[SRC_MEM*DATA_W +: DATA_W]),
    .size       (ctrl_q.mem_size),
    .mem_signed (ctrl_q.mem_signed),
    .off        (off_q),
    .aligned    (aligned)
  );

  always_comb begin
    wdata = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (sel_q == SEL_W'(k)) begin
        wdata = (k == SRC_MEM) ? aligned : src_q[k*DATA_W +: DATA_W];
      end
    end
  end

  assign commit = valid_q & ~done_q;
  assign we     = commit & ctrl_q.wb_en & ~(R0_ZERO && (waddr_q == '0));

  assign bus.reg_we    = we;
  assign bus.reg_waddr = waddr_q;
  assign bus.reg_wdata = wdata;
  assign bus.ret       = commit & ctrl_q.ret;
  assign bus.pcret     = pcret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_valid  <= 1'b0;
      byp_addr   <= '0;
      byp_data   <= '0;
      retire_cnt <= '0;
      bubble_cnt <= '0;
    end else begin
      if (we) begin
        byp_valid <= 1'b1;
        byp_addr  <= waddr_q;
        byp_data  <= wdata;
      end
      if (commit)   retire_cnt <= retire_cnt + CNT_W'(1);
      if (!valid_q) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_stage_p.sv
// Randomized scoreboard bench for wb_stage_p against an instruction-level reference model.
module tb_wb_stage_p;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int NSRC   = 3;
  localparam int CNT_W  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  wb_stage_p_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NSRC(NSRC)) bus ();

  logic              byp_valid;
  logic [ADDR_W-1:0] byp_addr;
  logic [DATA_W-1:0] byp_data;
  logic [CNT_W-1:0]  retire_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  wb_stage_p #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NSRC    (NSRC),
    .CNT_W   (CNT_W),
    .R0_ZERO (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .flush      (flush),
    .bus        (bus.slave),
    .byp_valid  (byp_valid),
    .byp_addr   (byp_addr),
    .byp_data   (byp_data),
    .retire_cnt (retire_cnt),
    .bubble_cnt (bubble_cnt)
  );

  typedef struct {
    bit          valid;
    bit          wb_en;
    logic [3:0]  addr;
    logic [1:0]  sel;
    logic [47:0] src;
    logic [1:0]  size;
    bit          sgn;
    logic        off;
    bit          ret;
    logic [15:0] pcret;
  } instr_t;

  typedef struct {
    bit          we;
    logic [3:0]  addr;
    logic [15:0] data;
    bit          ret;
    logic [15:0] pcret;
  } commit_t;

  commit_t sbq[$];
  commit_t mon_e;
  int vectors = 0;
  int errors  = 0;

  // Reference model: the instruction sitting in writeback and whether it has written yet.
  bit             m_valid = 0;
  bit             m_written = 0;
  instr_t         m_ins;
  logic [CNT_W-1:0] m_ret = '0;
  logic [CNT_W-1:0] m_bub = '0;
  bit             m_bv = 0;
  logic [3:0]     m_ba = '0;
  logic [15:0]    m_bd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(bit v, bit en, int a, int sel, logic [47:0] src,
                                int size, bit sgn, int off, bit r, logic [15:0] pc);
    instr_t i;
    i.valid = v;   i.wb_en = en;        i.addr = 4'(a);  i.sel = 2'(sel);
    i.src   = src; i.size  = 2'(size);  i.sgn  = sgn;    i.off = 1'(off);
    i.ret   = r;   i.pcret = pc;
    return i;
  endfunction

  function automatic logic [15:0] exp_data(instr_t i);
    int unsigned w;
    int unsigned v;
    case (i.sel)
      2'd0: return i.src[15:0];
      2'd2: return i.src[47:32];
      2'd3: return 16'h0000;
      default: ;
    endcase
    w = 32'(i.src[31:16]);
    if (i.size == 2'b10) begin
      v = (w >> (8 * int'(i.off))) % 256;
      if (i.sgn && v >= 128) v = v + 32'hFF00;
    end else begin
      v = w;
    end
    return 16'(v);
  endfunction

  function automatic bit writes(instr_t i);
    return i.wb_en && (i.addr != 4'd0);
  endfunction

  task automatic model_edge(bit st, bit fl, instr_t ins);
    bit commits;
    commits = m_valid && !m_written;
    if (commits) begin
      m_ret = m_ret + 1'b1;
      if (writes(m_ins)) begin
        m_bv = 1; m_ba = m_ins.addr; m_bd = exp_data(m_ins);
      end
    end
    if (!m_valid) m_bub = m_bub + 1'b1;
    if (fl) begin
      m_valid = 0; m_written = 0;
    end else if (st) begin
      if (commits) m_written = 1;
    end else begin
      m_ins = ins; m_valid = ins.valid; m_written = 0;
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_written = 0; m_ret = '0; m_bub = '0;
    m_bv = 0; m_ba = '0; m_bd = '0;
    m_ins = mk(0, 0, 0, 0, '0, 0, 0, 0, 0, 16'h0);
  endtask

  task automatic drive(instr_t i);
    bus.in_valid      = i.valid;
    bus.in_wb_en      = i.wb_en;
    bus.in_wb_addr    = i.addr;
    bus.in_src_sel    = i.sel;
    bus.in_src_data   = i.src;
    bus.in_mem_size   = i.size;
    bus.in_mem_signed = i.sgn;
    bus.in_byte_off   = i.off;
    bus.in_ret        = i.ret;
    bus.in_pcret      = i.pcret;
  endtask

  task automatic step(bit st, bit fl, instr_t ins);
    commit_t e;
    stall = st;
    flush = fl;
    drive(ins);
    @(posedge clk);
    model_edge(st, fl, ins);
    #1;
    if (m_valid && !m_written && (writes(m_ins) || m_ins.ret)) begin
      e.we = writes(m_ins); e.addr = m_ins.addr; e.data = exp_data(m_ins);
      e.ret = m_ins.ret; e.pcret = m_ins.pcret;
      sbq.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (bus.reg_we || bus.ret) begin
      if (sbq.size() == 0) begin
        vectors++; errors++;
        $display("FAIL unexpected_commit: we=%0b ret=%0b addr=%0h, expected no commit at %0t",
                 bus.reg_we, bus.ret, bus.reg_waddr, $time);
      end else begin
        mon_e = sbq.pop_front();
        chk("commit_we",  32'(bus.reg_we), 32'(mon_e.we));
        chk("commit_ret", 32'(bus.ret),    32'(mon_e.ret));
        if (mon_e.we) begin
          chk("commit_addr", 32'(bus.reg_waddr), 32'(mon_e.addr));
          chk("commit_data", 32'(bus.reg_wdata), 32'(mon_e.data));
        end
        if (mon_e.ret) chk("commit_pcret", 32'(bus.pcret), 32'(mon_e.pcret));
      end
    end else if (sbq.size() != 0) begin
      mon_e = sbq.pop_front();
      vectors++; errors++;
      $display("FAIL missing_commit: we=0 ret=0, expected we=%0b addr=%0h ret=%0b at %0t",
               mon_e.we, mon_e.addr, mon_e.ret, $time);
    end
    chk("retire_cnt", 32'(retire_cnt), 32'(m_ret));
    chk("bubble_cnt", 32'(bubble_cnt), 32'(m_bub));
    chk("byp_valid",  32'(byp_valid),  32'(m_bv));
    chk("byp_addr",   32'(byp_addr),   32'(m_ba));
    chk("byp_data",   32'(byp_data),   32'(m_bd));
  end

  instr_t idle;
  instr_t ri;

  initial begin
    model_reset();
    idle = mk(0, 0, 0, 0, '0, 0, 0, 0, 0, 16'h0);
    drive(idle);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_reg_we",  32'(bus.reg_we),    32'h0);
    chk("rst_wdata",   32'(bus.reg_wdata), 32'h0);
    chk("rst_pcret",   32'(bus.pcret),     32'h0);
    #2 rst_n = 1'b1;

    repeat (4) step(0, 0, idle);
    chk("idle_bubble", 32'(bubble_cnt), 32'd4);
    chk("idle_retire", 32'(retire_cnt), 32'd0);
    chk("idle_byp_v",  32'(byp_valid),  32'd0);
    chk("idle_we",     32'(bus.reg_we), 32'd0);

    step(0, 0, mk(1, 1, 3, 0, {32'h0, 16'h1234}, 0, 0, 0, 0, 16'h0));
    chk("alu_we",    32'(bus.reg_we),    32'd1);
    chk("alu_addr",  32'(bus.reg_waddr), 32'd3);
    chk("alu_data",  32'(bus.reg_wdata), 32'h1234);
    step(0, 0, idle);
    chk("alu_we_off",  32'(bus.reg_we), 32'd0);
    chk("alu_byp_a",   32'(byp_addr),   32'd3);
    chk("alu_byp_d",   32'(byp_data),   32'h1234);
    chk("alu_retire",  32'(retire_cnt), 32'd1);

    step(0, 0, mk(1, 1, 4, 1, {16'h0, 16'h80F0, 16'h0}, 2, 1, 0, 0, 16'h0));
    chk("ld_byte_s", 32'(bus.reg_wdata), 32'hFFF0);
    step(0, 0, mk(1, 1, 4, 1, {16'h0, 16'h80F0, 16'h0}, 2, 0, 1, 0, 16'h0));
    chk("ld_byte_u", 32'(bus.reg_wdata), 32'h0080);

    step(0, 0, mk(1, 1, 5, 1, {16'h0, 16'h8001, 16'h0}, 1, 1, 1, 0, 16'h0));
    chk("ld_half", 32'(bus.reg_wdata), 32'h8001);
    repeat (3) begin
      step(1, 0, idle);
      chk("stall_addr", 32'(bus.reg_waddr), 32'd5);
      chk("stall_data", 32'(bus.reg_wdata), 32'h8001);
    end
    step(0, 0, idle);

    step(1, 1, mk(1, 1, 7, 0, {32'h0, 16'hAAAA}, 0, 0, 0, 0, 16'h0));
    chk("flush_we", 32'(bus.reg_we), 32'd0);
    step(0, 0, idle);

    step(0, 0, mk(1, 1, 0, 0, {32'h0, 16'h5555}, 0, 0, 0, 0, 16'h0));
    chk("r0_we", 32'(bus.reg_we), 32'd0);
    step(0, 0, idle);

    step(0, 0, mk(1, 1, 6, 2, {16'h4321, 32'h0}, 0, 0, 0, 1, 16'h2468));
    step(1, 0, idle);
    step(1, 1, idle);
    step(0, 0, idle);

    for (int n = 0; n < 500; n++) begin
      ri = mk($urandom_range(99) < 80, $urandom_range(1), int'($urandom_range(15)),
              int'($urandom_range(3)), 48'({$urandom(), $urandom()}),
              int'($urandom_range(3)), $urandom_range(1), int'($urandom_range(1)),
              $urandom_range(99) < 20, 16'($urandom()));
      step($urandom_range(99) < 25, $urandom_range(99) < 10, ri);
    end

    step(0, 0, mk(1, 1, 9, 0, {32'h0, 16'hBEEF}, 0, 0, 0, 1, 16'h1111));
    step(1, 0, idle);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_we",     32'(bus.reg_we),    32'd0);
    chk("mrst_waddr",  32'(bus.reg_waddr), 32'd0);
    chk("mrst_wdata",  32'(bus.reg_wdata), 32'd0);
    chk("mrst_ret",    32'(bus.ret),       32'd0);
    chk("mrst_pcret",  32'(bus.pcret),     32'd0);
    chk("mrst_byp_v",  32'(byp_valid),     32'd0);
    chk("mrst_byp_a",  32'(byp_addr),      32'd0);
    chk("mrst_byp_d",  32'(byp_data),      32'd0);
    chk("mrst_retire", 32'(retire_cnt),    32'd0);
    chk("mrst_bubble", 32'(bubble_cnt),    32'd0);
    model_reset();
    stall = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) step(0, 0, idle);
    @(negedge clk);
    #1;
    chk("sb_drain", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
